serial_subtractor4: RTL and testbench
=====================================

SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled on a rising clk edge only when the block is idle or in DONE.
REQ-005 A  input  4  minuend; captured on the accepting edge.
REQ-006 B  input  4  subtrahend; captured on the accepting edge.
REQ-007 Bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress, from the accepting edge until done asserts.
REQ-009 done  output  1  single-cycle pulse: the result is valid.
REQ-010 D  output  4  difference; registered and held until the next done.
REQ-011 Bout  output  1  final borrow-out; registered and held with D.

Function
REQ-012 The block SHALL have three FSM states: IDLE, SHIFT and DONE; the state is IDLE after reset.
REQ-013 In IDLE, start=1 SHALL capture A, B and Bin, clear the 2-bit bit counter, set the borrow to Bin and move the FSM to SHIFT.
REQ-014 In SHIFT, each edge SHALL process bit i = counter, LSB first:
  - d_i = a_i ^ b_i ^ bw
  - bw' = (~a_i & b_i) | (~(a_i ^ b_i) & bw)
  - after processing, the counter increments.
REQ-015 In SHIFT, the edge that processes bit 3 SHALL load D and Bout from the completed result and move the FSM to DONE.
REQ-016 Result: {Bout,D} SHALL equal (A - B - Bin) mod 32, and Bout=1 iff A < B + Bin (unsigned).
REQ-017 Latency: done SHALL be high in the cycle after the 4th edge following the accepting edge, for exactly one cycle.
REQ-018 D and Bout SHALL NOT change during SHIFT; they update only on entry to DONE.
REQ-019 busy=1 in SHIFT, busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-020 start while in SHIFT SHALL be ignored, with no queueing and no effect on the operation in progress.
REQ-021 In DONE, start=1 SHALL accept new operands exactly as in IDLE and move the FSM directly to SHIFT, giving back-to-back operations every 5 cycles; with start=0, DONE moves to IDLE.
REQ-022 Operand inputs SHALL be don't-care except on the accepting edge.

Reset
REQ-023 resetn=0 SHALL immediately, without waiting for a clock edge, force:
  - state to IDLE;
  - counter, borrow and operand registers to 0;
  - busy, done, D and Bout to 0.
REQ-024 A reset asserted mid-SHIFT SHALL abort the operation, with no done pulse afterwards; the first start after resetn deasserts SHALL be processed normally.

Configuration
REQ-025 When the macro SERIAL_SUBTRACTOR4_FLAGS_EN is defined, the block SHALL add two outputs, both registered, loaded on entry to DONE, held with D, and reset to 0:
  - Z  output  1  Z = (D == 0).
  - V  output  1  V = (A[3] != B[3]) & (D[3] != A[3]); signed overflow, Bin included in D.
REQ-026 When SERIAL_SUBTRACTOR4_FLAGS_EN is undefined, the Z and V ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 A=7, B=3, Bin=0, start for 1 cycle -> busy for 4 cycles, then done 1 cycle with D=4, Bout=0; with flags: Z=0, V=0.
REQ-028 A=3, B=5, Bin=0 -> D=14, Bout=1; with flags: V=0.
  Also A=0, B=0, Bin=1 -> D=15, Bout=1.
REQ-029 A=8, B=1, Bin=0 -> D=7, Bout=0; with flags: V=1.
  Also A=5, B=5, Bin=0 -> D=0, Z=1.
REQ-030 start held high continuously with a new operand set each accept -> done every 5th cycle; each result matches its own operands.
  Also start pulses during SHIFT -> no change to the result or timing.
REQ-031 resetn pulsed low between edges during SHIFT -> outputs go to 0 immediately and no done follows; the next start (A=9, B=2, Bin=0) -> D=7, Bout=0.

Source files
------------

// File: rtl/serial_subtractor4_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor4_if
// Operand/result bundle for the bit-serial 4-bit subtractor.
//   start     request, sampled only when the block is idle or in DONE
//   A, B      minuend / subtrahend, captured on the accepting edge
//   Bin       borrow-in, captured on the accepting edge
//   busy      high while bits are being processed
//   done      one-cycle pulse, result valid
//   D, Bout   registered difference and final borrow-out
//   Z, V      zero / signed-overflow flags (only with SERIAL_SUBTRACTOR4_FLAGS_EN)
// master: operand producer.  slave: the subtractor.
// -----------------------------------------------------------------------------
interface serial_subtractor4_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [3:0] D;
    logic       Bout;
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
    logic       Z;
    logic       V;
`endif

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
        , input Z, V
`endif
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
        , output Z, V
`endif
    );
endinterface

// File: rtl/serial_subtractor4.sv
// -----------------------------------------------------------------------------
// serial_subtractor4
// Bit-serial 4-bit subtractor computing {Bout,D} = A - B - Bin, one bit per
// clock, LSB first, through a three-state FSM (IDLE -> SHIFT -> DONE).
// An accepted request yields done four edges later; starting again from DONE
// gives one result every 5 cycles.
//
// Ports
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset (clears state and all outputs)
//   bus     serial_subtractor4_if.slave (start, A, B, Bin, busy, done, D, Bout
//           and, with the macro below, Z and V)
//
// Configuration
//   SERIAL_SUBTRACTOR4_FLAGS_EN  when defined, adds registered Z (D == 0) and
//                                V (signed overflow) flags held alongside D.
// -----------------------------------------------------------------------------
module serial_subtractor4 (
    input  logic               clk,
    input  logic               resetn,
    serial_subtractor4_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] cnt;
    logic       bw;
    logic [2:0] d_sr;      // low difference bits, shifted in from the top
    logic [3:0] d_q;
    logic       bout_q;
    logic       busy_q;
    logic       done_q;
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
    logic       z_q;
    logic       v_q;
`endif

    logic       accept;
    logic       a_i;
    logic       b_i;
    logic       d_i;
    logic       bw_nxt;
    logic [3:0] d_full;

    // start only matters when no operation is in flight
    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    // One full-subtractor cell operating on the bit selected by the counter
    always_comb begin
        a_i    = a_q[cnt];
        b_i    = b_q[cnt];
        d_i    = a_i ^ b_i ^ bw;
        bw_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & bw);
        // on the last bit, d_sr already holds bits 2..0 in order
        d_full = {d_i, d_sr};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            a_q    <= 4'd0;
            b_q    <= 4'd0;
            cnt    <= 2'd0;
            bw     <= 1'b0;
            d_sr   <= 3'd0;
            d_q    <= 4'd0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
            z_q    <= 1'b0;
            v_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q    <= bus.A;
                b_q    <= bus.B;
                bw     <= bus.Bin;
                cnt    <= 2'd0;
                d_sr   <= 3'd0;
                busy_q <= 1'b1;
                state  <= SHIFT;
            end else if (state == SHIFT) begin
                d_sr <= {d_i, d_sr[2:1]};
                bw   <= bw_nxt;
                cnt  <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    // results are only published here, so D stays stable
                    // for the whole of SHIFT
                    d_q    <= d_full;
                    bout_q <= bw_nxt;
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
                    z_q    <= (d_full == 4'd0);
                    v_q    <= (a_q[3] != b_q[3]) && (d_full[3] != a_q[3]);
`endif
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
            end else begin
                // DONE without a new request, or an unreachable encoding
                state <= IDLE;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
    assign bus.Z    = z_q;
    assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor4.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor4
// Self-checking bench for serial_subtractor4. Expected results are queued when
// an operation is accepted and compared by a monitor on each done pulse.
// Flag checks are included when SERIAL_SUBTRACTOR4_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_subtractor4;

    typedef struct packed {
        logic [3:0] d;
        logic       bout;
        logic       z;
        logic       v;
    } exp_t;

    logic clk;
    logic resetn;

    serial_subtractor4_if bus ();

    serial_subtractor4 dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // monitor bookkeeping
    int         cyc       = 0;
    int         last_done = 0;
    bit         have_last = 0;
    bit         b2b       = 0;
    logic [3:0] held_d    = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bin);
        exp_t       e;
        logic [4:0] r;
        r      = {1'b0, a} - {1'b0, b} - {4'd0, bin};
        e.d    = r[3:0];
        e.bout = r[4];
        e.z    = (r[3:0] == 4'd0);
        e.v    = (a[3] != b[3]) && (r[3] != a[3]);
        return e;
    endfunction

    // Drive operands with start high and queue the expected result
    task automatic present(input logic [3:0] a, input logic [3:0] b, input logic bin);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        exp_q.push_back(model(a, b, bin));
    endtask

    // Single operation from IDLE; entered and left at posedge+1
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit poke);
        present(a, b, bin);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A     = 4'($urandom);
        bus.B     = 4'($urandom);
        bus.Bin   = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            check("busy_in_shift", bus.busy, 1);
            check("no_early_done", bus.done, 0);
            if (poke && (i % 2 == 1)) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check("done_latency", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
    endtask

    // Monitor: compares results on done, checks D holds during SHIFT
    always begin
        @(posedge clk); #2;
        cyc++;
        if (!resetn) begin
            held_d = 4'd0;
        end else begin
            if (bus.busy) check("d_hold_in_shift", bus.D, held_d);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", bus.done, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("D", bus.D, e.d);
                    check("Bout", bus.Bout, e.bout);
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
                    check("Z", bus.Z, e.z);
                    check("V", bus.V, e.v);
`endif
                end
                if (b2b && have_last) check("b2b_gap", cyc - last_done, 5);
                last_done = cyc;
                have_last = 1;
                held_d    = bus.D;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ops_a [4];
        logic [3:0] ops_b [4];
        logic       ops_c [4];
        ops_a = '{4'd1, 4'd14, 4'd6, 4'd12};
        ops_b = '{4'd2, 4'd7, 4'd6, 4'd3};
        ops_c = '{1'b0, 1'b1, 1'b0, 1'b0};

        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.A     = 4'd0;
        bus.B     = 4'd0;
        bus.Bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_D", bus.D, 0);
        check("rst_Bout", bus.Bout, 0);
`ifdef SERIAL_SUBTRACTOR4_FLAGS_EN
        check("rst_Z", bus.Z, 0);
        check("rst_V", bus.V, 0);
`endif
        resetn = 1'b1;
        @(posedge clk); #1;

        do_op(4'd7, 4'd3, 1'b0, 1'b0);
        do_op(4'd3, 4'd5, 1'b0, 1'b0);
        do_op(4'd0, 4'd0, 1'b1, 1'b0);
        do_op(4'd8, 4'd1, 1'b0, 1'b0);
        do_op(4'd5, 4'd5, 1'b0, 1'b0);
        do_op(4'd15, 4'd0, 1'b1, 1'b1);
        do_op(4'd2, 4'd9, 1'b1, 1'b1);

        // back-to-back: start held high, new operands after each accept
        b2b       = 1;
        have_last = 0;
        present(ops_a[0], ops_b[0], ops_c[0]);
        @(posedge clk); #1;
        for (int k = 1; k < 4; k++) begin
            present(ops_a[k], ops_b[k], ops_c[k]);
            repeat (5) @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        b2b = 0;
        check("b2b_drained", exp_q.size(), 0);

        // reset mid-SHIFT: operation is abandoned
        bus.start = 1'b1;
        bus.A     = 4'd4;
        bus.B     = 4'd1;
        bus.Bin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_D", bus.D, 0);
        check("abort_Bout", bus.Bout, 0);
        @(posedge clk); #3;
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", bus.done, 0);
        end

        do_op(4'd9, 4'd2, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
